// File: rtl/sdram_arb.sv
// Two-port round-robin arbiter in front of a single-request SDRAM controller.
// One transaction is in flight at a time; the read data register is shared by both ports.
module sdram_arb #(
  parameter int unsigned AW  = 21,
  parameter logic [7:0]  TMO = 8'd255
) (
  input  logic          clk_p,
  input  logic          nreset,

  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [1:0]    m0_sel,
  input  logic [AW:1]   m0_adr,
  input  logic [15:0]   m0_dat_i,
  output logic [15:0]   m0_dat_o,
  output logic          m0_ack,
  output logic          m0_err,

  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [1:0]    m1_sel,
  input  logic [AW:1]   m1_adr,
  input  logic [15:0]   m1_dat_i,
  output logic [15:0]   m1_dat_o,
  output logic          m1_ack,
  output logic          m1_err,

  output logic          mem_we,
  output logic          mem_rd,
  output logic [1:0]    mem_wtbt,
  output logic [AW:1]   mem_addr,
  output logic [15:0]   mem_din,
  input  logic [15:0]   mem_dout,
  input  logic          mem_ready,

  output logic          busy,
  output logic          grant
);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StStart,
    StWait,
    StAck
  } state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW:1]   addr_q, addr_d;
  logic [1:0]    wtbt_q, wtbt_d;
  logic [15:0]   din_q, din_d;
  logic [15:0]   dat_q, dat_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          busy_q;

  logic          sel_port;
  logic          tmo_hit;
  logic          req_active;
  logic          ack_state;

  // On a tie the port that was not granted last wins.
  always_comb begin
    if (m0_stb && m1_stb) begin
      sel_port = ~grant_q;
    end else begin
      sel_port = m1_stb;
    end
  end

  // Fires on the TMO-th cycle spent in StStart with the controller still ready.
  assign tmo_hit = (TMO != 8'd0) && (({1'b0, tmo_q} + 9'd1) >= {1'b0, TMO});

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wtbt_d  = wtbt_q;
    din_d   = din_q;
    dat_d   = dat_q;
    tmo_d   = tmo_q;
    err_d   = err_q;

    unique case (state_q)
      StInit: begin
        if (mem_ready) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (m0_stb || m1_stb) begin
          state_d = StStart;
          grant_d = sel_port;
          tmo_d   = 8'd0;
          err_d   = 1'b0;
          if (sel_port) begin
            we_d   = m1_we;
            addr_d = m1_adr;
            wtbt_d = m1_sel;
            din_d  = m1_dat_i;
          end else begin
            we_d   = m0_we;
            addr_d = m0_adr;
            wtbt_d = m0_sel;
            din_d  = m0_dat_i;
          end
        end
      end

      StStart: begin
        if (tmo_q != 8'hff) begin
          tmo_d = tmo_q + 8'd1;
        end
        if (!mem_ready) begin
          state_d = StWait;
        end else if (tmo_hit) begin
          state_d = StAck;
          err_d   = 1'b1;
        end
      end

      StWait: begin
        if (mem_ready) begin
          state_d = StAck;
          if (!we_q) begin
            dat_d = mem_dout;
          end
        end
      end

      StAck: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StInit;
      end
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (!nreset) begin
      state_q <= StInit;
      grant_q <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wtbt_q  <= 2'b00;
      din_q   <= 16'h0000;
      dat_q   <= 16'h0000;
      tmo_q   <= 8'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wtbt_q  <= wtbt_d;
      din_q   <= din_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign req_active = (state_q == StStart) || (state_q == StWait);
  assign ack_state  = (state_q == StAck);

  assign mem_rd   = req_active && !we_q;
  assign mem_we   = req_active && we_q;
  assign mem_addr = addr_q;
  assign mem_wtbt = wtbt_q;
  assign mem_din  = din_q;

  // Ack is gated by the live strobe so a requester that gave up sees nothing.
  assign m0_ack = ack_state && !grant_q && m0_stb;
  assign m1_ack = ack_state && grant_q && m1_stb;
  assign m0_err = m0_ack && err_q;
  assign m1_err = m1_ack && err_q;

  assign m0_dat_o = dat_q;
  assign m1_dat_o = dat_q;

  assign busy  = busy_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Scoreboard bench for sdram_arb: stimulus pushes expected acks and controller requests,
// a negedge monitor pops and compares them.
module tb_sdram_arb;

  localparam int unsigned AW = 21;

  logic          clk_p = 1'b0;
  logic          nreset;
  logic          m0_stb, m0_we, m1_stb, m1_we;
  logic [1:0]    m0_sel, m1_sel;
  logic [AW:1]   m0_adr, m1_adr;
  logic [15:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          mem_we, mem_rd;
  logic [1:0]    mem_wtbt;
  logic [AW:1]   mem_addr;
  logic [15:0]   mem_din, mem_dout;
  logic          mem_ready;
  logic          busy, grant;

  always #5 clk_p = ~clk_p;

  sdram_arb #(.AW(AW), .TMO(8'd10)) dut (
    .clk_p(clk_p), .nreset(nreset),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_wtbt(mem_wtbt), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready),
    .busy(busy), .grant(grant)
  );

  typedef struct {
    bit          port;
    bit          err;
    logic [15:0] dat;
    bit          chk_lat;
  } ack_exp_t;

  typedef struct {
    bit          we;
    logic [AW:1] addr;
    logic [1:0]  wtbt;
    logic [15:0] din;
  } req_exp_t;

  ack_exp_t ack_q[$];
  req_exp_t req_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic exp_ack(input bit p, input bit e, input logic [15:0] d, input bit l);
    ack_exp_t a;
    a.port = p; a.err = e; a.dat = d; a.chk_lat = l;
    ack_q.push_back(a);
  endtask

  task automatic exp_req(input bit w, input logic [AW:1] a, input logic [1:0] s,
                         input logic [15:0] d);
    req_exp_t r;
    r.we = w; r.addr = a; r.wtbt = s; r.din = d;
    req_q.push_back(r);
  endtask

  // Controller model: 0 holds ready low, 1 handshakes normally, 2 never drops ready.
  int          ctrl_mode = 0;
  int          ctrl_lat = 2;
  logic [15:0] ctrl_rdata = 16'h0000;
  int          cyc = 0;
  int          ready_rise_cyc = 0;

  always @(posedge clk_p) cyc <= cyc + 1;

  initial begin
    mem_ready = 1'b0;
    mem_dout  = 16'h0000;
    forever begin
      @(posedge clk_p);
      #1;
      if (ctrl_mode == 0) begin
        mem_ready = 1'b0;
      end else if (ctrl_mode == 2) begin
        mem_ready = 1'b1;
      end else if ((mem_rd || mem_we) && mem_ready) begin
        mem_ready = 1'b0;
        repeat (ctrl_lat) @(posedge clk_p);
        #1;
        mem_dout       = ctrl_rdata;
        mem_ready      = 1'b1;
        ready_rise_cyc = cyc;
      end else begin
        mem_ready = 1'b1;
      end
    end
  end

  logic req_prev = 1'b0;

  always @(negedge clk_p) begin
    ack_exp_t ae;
    req_exp_t re;
    logic     req_now;
    if (mem_rd && mem_we) begin
      checks++;
      errors++;
      $display("FAIL rd_we_overlap: got mem_rd=1 mem_we=1, required at most one high");
    end
    if (m0_ack || m1_ack) begin
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b, required none", m0_ack, m1_ack);
      end else begin
        ae = ack_q.pop_front();
        check("ack_port", 32'(m1_ack), 32'(ae.port));
        check("ack_other_low", 32'(ae.port ? m0_ack : m1_ack), 32'd0);
        check("ack_err", 32'(ae.port ? m1_err : m0_err), 32'(ae.err));
        check("ack_grant", 32'(grant), 32'(ae.port));
        check("dat_o_m0", 32'(m0_dat_o), 32'(ae.dat));
        check("dat_o_m1", 32'(m1_dat_o), 32'(ae.dat));
        if (ae.chk_lat) check("ack_latency", 32'(cyc), 32'(ready_rise_cyc + 1));
      end
    end
    req_now = mem_rd || mem_we;
    if (req_now && !req_prev) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request: got mem_rd=%0b mem_we=%0b, required none",
                 mem_rd, mem_we);
      end else begin
        re = req_q.pop_front();
        check("req_we", 32'(mem_we), 32'(re.we));
        check("req_addr", 32'(mem_addr), 32'(re.addr));
        check("req_wtbt", 32'(mem_wtbt), 32'(re.wtbt));
        if (re.we) check("req_din", 32'(mem_din), 32'(re.din));
      end
    end
    req_prev = req_now;
  end

  // Waits for an ack on one port; returns how many cycles a request was raised meanwhile.
  task automatic wait_ack(input bit port, output int req_cycles);
    bit seen = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_p);
      if (mem_rd || mem_we) req_cycles++;
      if (port ? m1_ack : m0_ack) seen = 1'b1;
    end
    check($sformatf("ack_seen_m%0d", port), 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    bit found;
    nreset = 1'b0;
    m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 2'b00; m0_adr = '0; m0_dat_i = 16'h0;
    m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 2'b00; m1_adr = '0; m1_dat_i = 16'h0;
    repeat (3) @(posedge clk_p);
    @(negedge clk_p);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd1);
    check("rst_dat_o", 32'(m0_dat_o), 32'h0000);
    @(posedge clk_p);
    #1;
    nreset = 1'b1;

    // Read requested while the controller is still initialising.
    exp_req(1'b0, 21'h000100, 2'b11, 16'h0);
    exp_ack(1'b0, 1'b0, 16'hA5C3, 1'b1);
    ctrl_rdata = 16'hA5C3;
    m0_we = 1'b0; m0_sel = 2'b11; m0_adr = 21'h000100; m0_stb = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk_p);
      if (mem_rd || mem_we) n++;
    end
    check("init_no_request", 32'(n), 32'd0);
    ctrl_mode = 1;
    @(posedge clk_p);
    #2;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clk_p);
      if (mem_rd) found = 1'b1;
    end
    check("init_rd_within_2", 32'(found), 32'd1);
    wait_ack(1'b0, n);
    @(posedge clk_p);
    #1;
    m0_stb = 1'b0;

    // Byte-masked write on port 1; the read register must keep the old value.
    exp_req(1'b1, 21'h000055, 2'b10, 16'h1234);
    exp_ack(1'b1, 1'b0, 16'hA5C3, 1'b1);
    ctrl_rdata = 16'hFFFF;
    m1_we = 1'b1; m1_sel = 2'b10; m1_adr = 21'h000055; m1_dat_i = 16'h1234; m1_stb = 1'b1;
    wait_ack(1'b1, n);
    @(posedge clk_p);
    #1;
    m1_stb = 1'b0;

    // Both strobes held: grants alternate starting with port 0.
    ctrl_rdata = 16'h5A5A;
    for (int k = 0; k < 3; k++) begin
      exp_req(1'b0, 21'h000200, 2'b11, 16'h0);
      exp_ack(1'b0, 1'b0, 16'h5A5A, 1'b1);
      exp_req(1'b1, 21'h000300, 2'b01, 16'hBEEF);
      exp_ack(1'b1, 1'b0, 16'h5A5A, 1'b1);
    end
    m0_we = 1'b0; m0_sel = 2'b11; m0_adr = 21'h000200;
    m1_we = 1'b1; m1_sel = 2'b01; m1_adr = 21'h000300; m1_dat_i = 16'hBEEF;
    m0_stb = 1'b1;
    m1_stb = 1'b1;
    fork
      begin
        int c0;
        repeat (3) wait_ack(1'b0, c0);
        @(posedge clk_p);
        #1;
        m0_stb = 1'b0;
      end
      begin
        int c1;
        repeat (3) wait_ack(1'b1, c1);
        @(posedge clk_p);
        #1;
        m1_stb = 1'b0;
      end
    join

    // Controller never accepts: abort after TMO=10 request cycles.
    @(negedge clk_p);
    ctrl_mode = 2;
    exp_req(1'b0, 21'h000ABC, 2'b11, 16'h0);
    exp_ack(1'b0, 1'b1, 16'h5A5A, 1'b0);
    @(posedge clk_p);
    #1;
    m0_adr = 21'h000ABC; m0_stb = 1'b1;
    wait_ack(1'b0, n);
    check("tmo_request_cycles", 32'(n), 32'd10);
    @(posedge clk_p);
    #1;
    m0_stb = 1'b0;
    @(negedge clk_p);
    check("tmo_idle_busy", 32'(busy), 32'd0);
    ctrl_mode = 1;

    // Reset while waiting on the controller, then serve port 1 once ready returns.
    @(posedge clk_p);
    #1;
    ctrl_lat = 20;
    exp_req(1'b0, 21'h000777, 2'b11, 16'h0);
    m0_adr = 21'h000777; m0_stb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk_p);
      if (mem_rd && !mem_ready) found = 1'b1;
    end
    check("reach_wait", 32'(found), 32'd1);
    @(negedge clk_p);
    nreset = 1'b0;
    @(posedge clk_p);
    #1;
    nreset = 1'b1;
    m0_stb = 1'b0;
    ctrl_lat = 2;
    ctrl_rdata = 16'hC0DE;
    exp_req(1'b0, 21'h001234, 2'b11, 16'h0);
    exp_ack(1'b1, 1'b0, 16'hC0DE, 1'b1);
    m1_we = 1'b0; m1_sel = 2'b11; m1_adr = 21'h001234; m1_stb = 1'b1;
    @(negedge clk_p);
    check("rst2_mem_rd", 32'(mem_rd), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_dat_o", 32'(m0_dat_o), 32'h0000);
    check("rst2_grant", 32'(grant), 32'd1);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_p);
      if (mem_ready) found = 1'b1;
      else if (mem_rd || mem_we) n++;
    end
    check("rst2_ready_seen", 32'(found), 32'd1);
    check("rst2_no_req_before_ready", 32'(n), 32'd0);
    wait_ack(1'b1, n);
    @(posedge clk_p);
    #1;
    m1_stb = 1'b0;

    repeat (5) @(negedge clk_p);
    check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
